// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/exec/mem/wb over a shared memory port.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [TIMEOUT_W-1:0] LIMIT =
    TIMEOUT_W'(MEM_TIMEOUT);

  state_t cur, nxt;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic       trap_q, trap_nxt;
  logic [1:0] cause_q, cause_nxt;

  logic [6:0] opc;
  logic is_r, is_i, is_ld, is_s, is_b;
  logic is_lui, is_auipc, is_jal, is_jalr, is_fence;
  logic legal, rd_nz, tmo, alu_phase;
  logic unused_instr;

  assign opc      = instr[6:0];
  assign rd_nz    = |instr[11:7];
  assign is_r     = opc == 7'b0110011;
  assign is_i     = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_s     = opc == 7'b0100011;
  assign is_b     = opc == 7'b1100011;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_fence = opc == 7'b0001111;
  assign legal    = is_r | is_i | is_ld | is_s | is_b |
                    is_lui | is_auipc | is_jal |
                    is_jalr | is_fence;
  assign unused_instr = ^instr[31:12];

  // rdy in the limit cycle wins over the timeout
  assign tmo = (MEM_TIMEOUT != 0) && (cnt == LIMIT) &&
               !mem_rdy;

  assign alu_phase = (cur == S_EXEC) || (cur == S_MEM) ||
                     (cur == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      cnt     <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_nxt;
      trap_q  <= trap_nxt;
      cause_q <= cause_nxt;
    end
  end

  always_comb begin
    nxt          = cur;
    cnt_nxt      = '0;
    trap_nxt     = trap_q;
    cause_nxt    = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    alu_op       = 2'd0;
    retire       = 1'b0;

    if (alu_phase) begin
      unique case (1'b1)
        is_r: alu_op = 2'd1;
        is_i: begin
          alu_b_sel = 1'b1;
          alu_op    = 2'd1;
        end
        is_ld, is_s, is_jalr: alu_b_sel = 1'b1;
        is_b: alu_op = 2'd2;
        is_lui: begin
          alu_a_sel = 2'd2;
          alu_b_sel = 1'b1;
        end
        is_auipc: begin
          alu_a_sel = 2'd1;
          alu_b_sel = 1'b1;
        end
        default: ;
      endcase
    end

    unique case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (tmo) begin
          nxt       = S_TRAP;
          trap_nxt  = 1'b1;
          cause_nxt = 2'd2;
        end else begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          nxt = S_EXEC;
        end else begin
          nxt       = S_TRAP;
          trap_nxt  = 1'b1;
          cause_nxt = 2'd1;
        end
      end
      S_EXEC: begin
        if (is_ld || is_s) begin
          nxt = S_MEM;
        end else if (is_b) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? 2'd1 : 2'd0;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (is_fence) begin
          pc_we  = 1'b1;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_s;
        if (mem_rdy) begin
          if (is_s) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (tmo) begin
          nxt       = S_TRAP;
          trap_nxt  = 1'b1;
          cause_nxt = 2'd2;
        end else begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      S_WB: begin
        reg_we = rd_nz;
        pc_we  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
        if (is_ld) begin
          wb_sel = 2'd1;
        end else if (is_jal || is_jalr) begin
          wb_sel = 2'd2;
        end
        if (is_jal) begin
          pc_src = 2'd1;
        end else if (is_jalr) begin
          pc_src = 2'd2;
        end
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IDLE;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an
// instruction-level latency/outcome model.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we;
  logic        pc_we, reg_we, alu_b_sel, retire, trap;
  logic [1:0]  pc_src, wb_sel, alu_a_sel, alu_op;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT(TO),
    .TIMEOUT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr(instr),
    .br_taken(br_taken),
    .mem_rdy(mem_rdy),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we),
    .pc_we(pc_we),
    .pc_src(pc_src),
    .reg_we(reg_we),
    .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel),
    .alu_op(alu_op),
    .retire(retire),
    .trap(trap),
    .trap_cause(trap_cause),
    .state(state)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [19:0] all_outs();
    return {mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
            pc_src, reg_we, wb_sel, alu_a_sel, alu_b_sel,
            alu_op, retire, trap, trap_cause};
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_rdy = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_state", state, 0);
    check("idle_outs", all_outs(), 0);
    @(negedge clk);
  endtask

  // One instruction from its first FETCH cycle to retire/trap.
  task automatic run_instr(input logic [31:0] ins,
                           input int fw, input int mw);
    logic [6:0] op;
    bit ld, st, has_rd, trapped, done;
    int exp_cyc, exp_cause, cyc, phase, waited, base;
    logic [4:0] exp_alu;
    logic [1:0] exp_src, exp_wb;
    logic [2:0] exp_st;
    bit rdy;
    op = ins[6:0];
    ld = op == 7'h03;
    st = op == 7'h23;
    case (op)
      7'h63, 7'h0F: base = 3;
      7'h03:        base = 5;
      default:      base = 4;
    endcase
    exp_cause = 0;
    if (fw > TO) begin
      exp_cause = 2;
      exp_cyc   = TO + 2;
    end else if (!legal(op)) begin
      exp_cause = 1;
      exp_cyc   = fw + 3;
    end else if ((ld || st) && mw > TO) begin
      exp_cause = 2;
      exp_cyc   = fw + TO + 5;
    end else begin
      exp_cyc = base + fw + ((ld || st) ? mw : 0);
    end
    case (op)
      7'h33:               exp_alu = {2'd0, 1'b0, 2'd1};
      7'h13:               exp_alu = {2'd0, 1'b1, 2'd1};
      7'h03, 7'h23, 7'h67: exp_alu = {2'd0, 1'b1, 2'd0};
      7'h63:               exp_alu = {2'd0, 1'b0, 2'd2};
      7'h37:               exp_alu = {2'd2, 1'b1, 2'd0};
      7'h17:               exp_alu = {2'd1, 1'b1, 2'd0};
      default:             exp_alu = 5'd0;
    endcase
    case (op)
      7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67:
        has_rd = ins[11:7] != 0;
      default: has_rd = 1'b0;
    endcase
    exp_wb = ld ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : 2'd0;
    case (op)
      7'h63, 7'h0F: exp_st = 3'd3;
      7'h23:        exp_st = 3'd4;
      default:      exp_st = 3'd5;
    endcase
    instr   = ins;
    cyc     = 0;
    phase   = 0;
    waited  = 0;
    done    = 1'b0;
    trapped = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      br_taken = 1'($urandom);
      if (mem_req) rdy = waited >= ((phase == 0) ? fw : mw);
      else rdy = 1'($urandom);
      mem_rdy = rdy;
      #1;
      if (mem_req) begin
        check("addr_sel", mem_addr_sel, phase);
        check("mem_we", mem_we, (phase == 1) && st);
      end
      check("ir_we", ir_we, mem_req && phase == 0 && rdy);
      if (state == 3'd6) begin
        done    = 1'b1;
        trapped = 1'b1;
        check("trap_req_drop", mem_req, 0);
      end else if (retire) begin
        done = 1'b1;
        exp_src = (op == 7'h63) ? {1'b0, br_taken} :
                  (op == 7'h6F) ? 2'd1 :
                  (op == 7'h67) ? 2'd2 : 2'd0;
        check("ret_pc_we", pc_we, 1);
        check("ret_pc_src", pc_src, exp_src);
        check("ret_reg_we", reg_we, has_rd);
        check("ret_wb_sel", wb_sel, exp_wb);
        check("ret_alu", {alu_a_sel, alu_b_sel, alu_op}, exp_alu);
        check("ret_state", state, exp_st);
      end else begin
        check("quiet", {pc_we, reg_we}, 0);
      end
      if (mem_req) begin
        if (rdy) begin
          phase++;
          waited = 0;
        end else begin
          waited++;
        end
      end
      @(negedge clk);
    end
    check("bound", done, 1);
    check("latency", cyc, exp_cyc);
    if (trapped || exp_cause != 0) begin
      for (int i = 0; i < 20; i++) begin
        mem_rdy = 1'($urandom);
        #1;
        check("trap_hold", {state, trap, trap_cause, mem_req, pc_we},
              {3'd6, 1'b1, 2'(exp_cause), 1'b0, 1'b0});
        @(negedge clk);
      end
      do_reset();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F};
    r = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      do op = 7'($urandom); while (legal(op));
    end else begin
      op = ops[$urandom_range(0, 9)];
    end
    return {r[31:7], op};
  endfunction

  function automatic int rand_wait();
    if ($urandom_range(0, 11) == 0) return TO + 1;
    return $urandom_range(0, TO);
  endfunction

  initial begin
    do_reset();
    run_instr(32'h00500093, 0, 0);
    run_instr(32'h0000A103, 0, 3);
    run_instr(32'h00208463, 0, 0);
    run_instr(32'h00208463, 1, 0);
    run_instr(32'h0080006F, 0, 0);
    run_instr(32'h000080E7, 0, 0);
    run_instr(32'h00112023, 2, 1);
    run_instr(32'h0000000F, 0, 0);
    run_instr(32'h00500093, TO, 0);
    run_instr(32'h0000A103, 0, TO);
    run_instr(32'h00000073, 0, 0);
    run_instr(32'h00500093, TO + 1, 0);
    run_instr(32'h00112023, 0, TO + 1);
    for (int n = 0; n < 150; n++)
      run_instr(rand_instr(), rand_wait(), rand_wait());
    mem_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", mem_req, 0);
    check("async_rst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
